// File: rtl/keypad_hex16.sv
// keypad_hex16: scans a 4x4 active-low matrix keypad, debounces presses and releases,
// and shifts each accepted key nibble into a 16-bit entry register from the right.
module keypad_hex16 #(
   parameter int unsigned SCAN_DIV     = 1024,
   parameter int unsigned DEBOUNCE_CNT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row,
   input  logic        clr,
   output logic [3:0]  col,
   output logic [15:0] value,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        pressed
);

   localparam int unsigned SlotW = $clog2(SCAN_DIV);
   localparam int unsigned CntW  = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0]  CntDone  = CntW'(DEBOUNCE_CNT);
   localparam logic [CntW-1:0]  CntOne   = CntW'(1);

   typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

   function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] nib;
      unique case ({r, c})
         4'h0: nib = 4'h1;
         4'h1: nib = 4'h2;
         4'h2: nib = 4'h3;
         4'h3: nib = 4'hA;
         4'h4: nib = 4'h4;
         4'h5: nib = 4'h5;
         4'h6: nib = 4'h6;
         4'h7: nib = 4'hB;
         4'h8: nib = 4'h7;
         4'h9: nib = 4'h8;
         4'hA: nib = 4'h9;
         4'hB: nib = 4'hC;
         4'hC: nib = 4'h0;
         4'hD: nib = 4'hF;
         4'hE: nib = 4'hE;
         4'hF: nib = 4'hD;
      endcase
      return nib;
   endfunction

   logic [3:0]       row_meta_q, rs_q;
   logic [SlotW-1:0] slot_q;
   state_e           state_q, state_d;
   logic [1:0]       k_q, k_d;
   logic [1:0]       ridx_q, ridx_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [CntW-1:0]  cnt_inc;
   logic [3:0]       col_q, col_d;
   logic [15:0]      value_q;
   logic [3:0]       key_code_q;
   logic             key_valid_q;
   logic             sample;
   logic             accept;
   logic             rs_one_low;
   logic [1:0]       rs_idx;
   logic [3:0]       new_code;

   assign sample  = (slot_q == SlotLast);
   assign cnt_inc = cnt_q + CntOne;

   // Exactly one row low identifies a single key; anything else is idle or a ghost.
   always_comb begin
      rs_one_low = 1'b1;
      rs_idx     = 2'd0;
      unique case (rs_q)
         4'b1110: rs_idx = 2'd0;
         4'b1101: rs_idx = 2'd1;
         4'b1011: rs_idx = 2'd2;
         4'b0111: rs_idx = 2'd3;
         default: rs_one_low = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      ridx_d  = ridx_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      if (sample) begin
         unique case (state_q)
            StScan: begin
               if (rs_one_low) begin
                  ridx_d = rs_idx;
                  cnt_d  = CntOne;
                  if (CntOne == CntDone) begin
                     accept  = 1'b1;
                     state_d = StHeld;
                     cnt_d   = '0;
                  end else begin
                     state_d = StDebounce;
                  end
               end else begin
                  k_d = k_q + 2'd1;
               end
            end
            StDebounce: begin
               if (rs_q == ~(4'b0001 << ridx_q)) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CntDone) begin
                     accept  = 1'b1;
                     state_d = StHeld;
                     cnt_d   = '0;
                  end
               end else begin
                  state_d = StScan;
                  cnt_d   = '0;
                  k_d     = k_q + 2'd1;
               end
            end
            StHeld: begin
               if (rs_q == 4'b1111) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CntDone) begin
                     state_d = StScan;
                     cnt_d   = '0;
                     k_d     = k_q + 2'd1;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: begin
               state_d = StScan;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign new_code = keymap(ridx_d, k_q);
   assign col_d    = ~(4'b0001 << k_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta_q  <= 4'hF;
         rs_q        <= 4'hF;
         slot_q      <= '0;
         state_q     <= StScan;
         k_q         <= 2'd0;
         ridx_q      <= 2'd0;
         cnt_q       <= '0;
         col_q       <= 4'b1110;
         value_q     <= 16'h0000;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
      end else begin
         row_meta_q  <= row;
         rs_q        <= row_meta_q;
         slot_q      <= sample ? '0 : slot_q + SlotW'(1);
         state_q     <= state_d;
         k_q         <= k_d;
         ridx_q      <= ridx_d;
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         key_valid_q <= accept;
         if (accept) begin
            key_code_q <= new_code;
         end
         // Clear wins over a same-cycle accept.
         if (clr) begin
            value_q <= 16'h0000;
         end else if (accept) begin
            value_q <= {value_q[11:0], new_code};
         end
      end
   end

   assign col       = col_q;
   assign value     = value_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign pressed   = (state_q == StHeld);

endmodule
